// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: buffers sprite update requests in a small FIFO and
// serialises each into four writedata words (attribute, X, Y, shift) aimed
// at the back buffer. Emits a flush/swap word after each frame_sync.
// Optional build macro: SPRITE_CMD_STATS_EN adds frame_count/overrun_count.
module sprite_cmd_encoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  INFO_WRITE = 4'b0001,
    parameter logic [3:0]  INFO_FLUSH = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_sub_comp,
    input  logic [4:0]  req_child,
    input  logic        req_visible,
    input  logic        req_flip,
    input  logic [4:0]  req_pattern,
    input  logic [9:0]  req_x,
    input  logic [9:0]  req_y,
    input  logic [9:0]  req_shift,
    input  logic        frame_sync,
    output logic [31:0] writedata,
    output logic        front_buf,
    output logic        busy
`ifdef SPRITE_CMD_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] overrun_count
`endif
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = 48;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ATTR, XPOS, YPOS, SHIFT, FLUSH} state_t;

    state_t               state, state_n;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   cur_req;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 rdy_en;
    logic                 flush_pend, flush_pend_n;
    logic                 push, pop, empty, full;
    logic                 enter_flush, overrun;
    logic [31:0]          word_n;
    logic                 pp;

    logic [5:0] c_sub;
    logic [4:0] c_child;
    logic       c_vis, c_flip;
    logic [4:0] c_pat;
    logic [9:0] c_x, c_y, c_shift;

    assign {c_sub, c_child, c_vis, c_flip, c_pat, c_x, c_y, c_shift} = cur_req;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_CNT);
    assign req_ready = rdy_en & ~full;
    assign push      = req_valid & req_ready;
    assign pp        = ~front_buf;
    assign busy      = ~empty | (state != IDLE) | flush_pend;

    // Ready is held low through reset and for the reset cycle itself.
    always_ff @(posedge clk) begin
        rdy_en <= ~reset;
    end

    // FIFO storage; written only on accepted requests.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {req_sub_comp, req_child, req_visible, req_flip,
                            req_pattern, req_x, req_y, req_shift};
    end

    // FIFO pointers and occupancy; a popped entry is latched for the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cur_req <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                cur_req <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Next-state selection: flush first, then a new burst, else idle.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE, SHIFT: begin
                if (flush_pend) begin
                    state_n = FLUSH;
                end else if (!empty) begin
                    state_n = ATTR;
                    pop     = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            ATTR:  state_n = XPOS;
            XPOS:  state_n = YPOS;
            YPOS:  state_n = SHIFT;
            FLUSH: begin
                if (!empty) begin
                    state_n = ATTR;
                    pop     = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Flush-pending bookkeeping; a frame_sync on FLUSH entry starts a new request.
    always_comb begin
        enter_flush  = (state_n == FLUSH);
        overrun      = frame_sync & flush_pend & ~enter_flush;
        flush_pend_n = (flush_pend & ~enter_flush) | frame_sync;
    end

    // Word for the current state; registered next edge so each lasts one cycle.
    always_comb begin
        word_n = '0;
        case (state)
            ATTR:  word_n = {c_sub, c_child, INFO_WRITE, 3'b001, pp,
                             c_vis, c_flip, 6'b0, c_pat};
            XPOS:  word_n = {c_sub, c_child, INFO_WRITE, 3'b010, pp, 3'b0, c_x};
            YPOS:  word_n = {c_sub, c_child, INFO_WRITE, 3'b011, pp, 3'b0, c_y};
            SHIFT: word_n = {c_sub, c_child, INFO_WRITE, 3'b100, pp, 3'b0, c_shift};
            FLUSH: word_n = {11'b0, INFO_FLUSH, 3'b000, pp, 13'b0};
            default: word_n = '0;
        endcase
    end

    // State, output word and buffer-select registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            writedata  <= '0;
            front_buf  <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_n;
            writedata  <= word_n;
            flush_pend <= flush_pend_n;
            if (state == FLUSH)
                front_buf <= ~front_buf;
        end
    end

`ifdef SPRITE_CMD_STATS_EN
    // Saturating flush and coalesced-frame_sync counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            if (state == FLUSH && frame_count != '1)
                frame_count <= frame_count + 1'b1;
            if (overrun && overrun_count != '1)
                overrun_count <= overrun_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Scoreboard bench for sprite_cmd_encoder: a transaction-level model predicts
// each output word with its arrival edge; a negedge monitor pops and compares.
module tb_sprite_cmd_encoder;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_sub_comp = '0;
    logic [4:0]  req_child = '0;
    logic        req_visible = 1'b0;
    logic        req_flip = 1'b0;
    logic [4:0]  req_pattern = '0;
    logic [9:0]  req_x = '0;
    logic [9:0]  req_y = '0;
    logic [9:0]  req_shift = '0;
    logic        frame_sync = 1'b0;
    logic [31:0] writedata;
    logic        front_buf;
    logic        busy;
`ifdef SPRITE_CMD_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] overrun_count;
`endif

    sprite_cmd_encoder #(
        .FIFO_DEPTH (DEPTH),
        .INFO_WRITE (4'b0001),
        .INFO_FLUSH (4'b1111)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sub_comp (req_sub_comp),
        .req_child    (req_child),
        .req_visible  (req_visible),
        .req_flip     (req_flip),
        .req_pattern  (req_pattern),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_shift    (req_shift),
        .frame_sync   (frame_sync),
        .writedata    (writedata),
        .front_buf    (front_buf),
        .busy         (busy)
`ifdef SPRITE_CMD_STATS_EN
        ,
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sub, child, vis, flip, pat, x, y, sh;
    } req_t;

    typedef struct {
        logic [31:0] word;
        int unsigned due;
    } exp_t;

    req_t        m_q[$];
    exp_t        exp_q[$];
    int unsigned edge_n = 0;
    int unsigned m_next_dec = 0;
    int unsigned m_toggle_at = 0;
    int unsigned m_frames = 0;
    int unsigned m_overruns = 0;
    bit          m_pend = 0, m_last_flush = 0, m_engaged = 0, m_rdy_en = 0;
    bit          m_front_sched = 0, exp_front = 0;
    bit          exp_ready = 0, exp_busy = 0;
    bit          started = 0;
    int unsigned n_vec = 0, n_fail = 0;

    function automatic logic [31:0] mk_word(int unsigned sub, int unsigned child,
                                            int unsigned info, int unsigned typ,
                                            int unsigned pp, int unsigned msg);
        return 32'(sub * (2 ** 26) + child * (2 ** 21) + info * (2 ** 17) +
                   typ * (2 ** 14) + pp * (2 ** 13) + msg);
    endfunction

    // Reference model: engine decides at decision edges; flush beats a new
    // burst unless it just flushed; a burst occupies four cycles.
    always @(posedge clk) begin : model
        bit   rdy_pre;
        req_t r;
        int unsigned pp;
        edge_n  = edge_n + 1;
        rdy_pre = m_rdy_en && (m_q.size() < DEPTH);
        if (reset) begin
            started       = 1;
            m_q.delete();
            exp_q.delete();
            m_pend        = 0;
            m_last_flush  = 0;
            m_engaged     = 0;
            m_rdy_en      = 0;
            m_front_sched = 0;
            exp_front     = 0;
            m_toggle_at   = 0;
            m_frames      = 0;
            m_overruns    = 0;
            m_next_dec    = edge_n + 1;
        end else begin
            if (m_toggle_at == edge_n) begin
                exp_front = !exp_front;
                m_frames  = m_frames + 1;
            end
            if (edge_n == m_next_dec) begin
                if (m_pend && !m_last_flush) begin
                    pp = m_front_sched ? 0 : 1;
                    exp_q.push_back('{mk_word(0, 0, 15, 0, pp, 0), edge_n + 1});
                    m_front_sched = !m_front_sched;
                    m_toggle_at   = edge_n + 1;
                    m_pend        = 0;
                    m_next_dec    = edge_n + 1;
                    m_last_flush  = 1;
                    m_engaged     = 1;
                end else if (m_q.size() != 0) begin
                    r  = m_q.pop_front();
                    pp = m_front_sched ? 0 : 1;
                    exp_q.push_back('{mk_word(r.sub, r.child, 1, 1, pp,
                                      r.vis * 4096 + r.flip * 2048 + r.pat), edge_n + 1});
                    exp_q.push_back('{mk_word(r.sub, r.child, 1, 2, pp, r.x), edge_n + 2});
                    exp_q.push_back('{mk_word(r.sub, r.child, 1, 3, pp, r.y), edge_n + 3});
                    exp_q.push_back('{mk_word(r.sub, r.child, 1, 4, pp, r.sh), edge_n + 4});
                    m_next_dec   = edge_n + 4;
                    m_last_flush = 0;
                    m_engaged    = 1;
                end else begin
                    m_next_dec   = edge_n + 1;
                    m_last_flush = 0;
                    m_engaged    = 0;
                end
            end
            if (frame_sync) begin
                if (m_pend) m_overruns = m_overruns + 1;
                m_pend = 1;
            end
            if (req_valid && rdy_pre)
                m_q.push_back('{req_sub_comp, req_child, req_visible, req_flip,
                                req_pattern, req_x, req_y, req_shift});
            m_rdy_en = 1;
        end
        exp_ready = m_rdy_en && (m_q.size() < DEPTH);
        exp_busy  = (m_q.size() != 0) || m_pend || m_engaged;
    end

    // Monitor: compares handshake/status every cycle and pops on each word.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (started) begin
            n_vec = n_vec + 1;
            if (req_ready !== exp_ready) begin
                n_fail = n_fail + 1;
                $display("FAIL req_ready edge %0d: got %b want %b", edge_n, req_ready, exp_ready);
            end
            n_vec = n_vec + 1;
            if (busy !== exp_busy) begin
                n_fail = n_fail + 1;
                $display("FAIL busy edge %0d: got %b want %b", edge_n, busy, exp_busy);
            end
            n_vec = n_vec + 1;
            if (front_buf !== exp_front) begin
                n_fail = n_fail + 1;
                $display("FAIL front_buf edge %0d: got %b want %b", edge_n, front_buf, exp_front);
            end
`ifdef SPRITE_CMD_STATS_EN
            n_vec = n_vec + 1;
            if (frame_count !== 16'(m_frames) || overrun_count !== 16'(m_overruns)) begin
                n_fail = n_fail + 1;
                $display("FAIL stats edge %0d: got %0d/%0d want %0d/%0d", edge_n,
                         frame_count, overrun_count, m_frames, m_overruns);
            end
`endif
            if (writedata !== 32'h0) begin
                n_vec = n_vec + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL word edge %0d: got %h want none (idle 0)", edge_n, writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (writedata !== e.word || edge_n != e.due) begin
                        n_fail = n_fail + 1;
                        $display("FAIL word edge %0d: got %h want %h at edge %0d",
                                 edge_n, writedata, e.word, e.due);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= edge_n) begin
                n_vec = n_vec + 1;
                n_fail = n_fail + 1;
                e = exp_q.pop_front();
                $display("FAIL word edge %0d: got 00000000 want %h", edge_n, e.word);
            end
        end
    end

    task automatic step(input bit v, input bit fs, input bit rst);
        @(negedge clk);
        req_valid    = v;
        frame_sync   = fs;
        reset        = rst;
        req_sub_comp = 6'($urandom);
        req_child    = 5'($urandom);
        req_visible  = 1'($urandom);
        req_flip     = 1'($urandom);
        req_pattern  = 5'($urandom);
        req_x        = 10'($urandom);
        req_y        = 10'($urandom);
        req_shift    = 10'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        repeat (3) step(0, 0, 1);
        idle(2);

        // Single directed request.
        @(negedge clk);
        req_valid = 1; frame_sync = 0; reset = 0;
        req_sub_comp = 6'd14; req_child = 5'd0; req_visible = 1; req_flip = 0;
        req_pattern = 5'd0; req_x = 10'd100; req_y = 10'd50; req_shift = 10'd3;
        idle(10);

        // Flush from idle.
        step(0, 1, 0);
        idle(6);

        // Fill the FIFO past full while a flush is pending.
        step(1, 1, 0);
        for (int i = 0; i < 14; i++) step(1, 0, 0);
        idle(60);

        // frame_sync during the ATTR cycle, then a following burst.
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        idle(20);

        // Two frame_sync pulses mid-burst coalesce into one flush.
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        idle(20);

        // Reset during a burst.
        step(1, 0, 0);
        idle(3);
        step(0, 0, 1);
        idle(10);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 499) == 0);
        idle(100);

        n_vec = n_vec + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: got %0d words outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
